spi_slave_framed: RTL and testbench

SPI_SLAVE_FRAMED -- requirements
Module: spi_slave_framed

---
 rtl/spi_slave_framed_pkg.sv | 16 +
 rtl/spi_tx_fifo.sv | 51 +++++
 rtl/spi_slave_framed.sv | 112 +++++++++++
 tb/tb_spi_slave_framed.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_framed_pkg.sv
// rtl/spi_slave_framed_pkg.sv - shared constants and bit-ordering helpers for the framed SPI slave
package spi_slave_framed_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  // One frame is the payload plus a trailing flag/pad bit.
  function automatic int frame_len(input int word_width);
    return word_width + 1;
  endfunction

  // Wire position of payload bit idx for the selected bit order.
  function automatic int wire_pos(input int idx, input int word_width, input bit msb_first);
    return msb_first ? (word_width - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - slave-to-master word FIFO with level count
module spi_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         SCLK,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge SCLK) begin
    if (rst && push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Callers never push when full or pop when empty, so the level cannot wrap.
  always_ff @(posedge SCLK) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_framed.sv
// rtl/spi_slave_framed.sv - chip-select-less SPI slave exchanging fixed-length flagged frames
module spi_slave_framed
  import spi_slave_framed_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int TX_DEPTH   = 4,
  parameter bit FLAG_MODE  = 1'b0,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                             SCLK,
  input  logic                             rst,
  input  logic                             MOSI,
  output logic                             MISO,
  output logic [WORD_WIDTH-1:0]            rx_data,
  output logic                             rx_valid,
  input  logic [WORD_WIDTH-1:0]            tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0]    tx_level
);

  localparam int FRAME_LEN = frame_len(WORD_WIDTH);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH);

  logic [CW-1:0]         bit_cnt;
  logic                  last_bit;
  logic [WORD_WIDTH-1:0] rx_shift;
  logic [WORD_WIDTH-1:0] rx_next;
  logic [WORD_WIDTH-1:0] tx_shift;
  logic                  tx_flag;
  logic [WORD_WIDTH:0]   tx_wire;
  logic                  miso_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] fifo_rdata;

  assign last_bit = (bit_cnt == LAST_BIT);
  assign tx_ready = !fifo_full;
  assign push     = tx_valid && !fifo_full;
  assign pop      = last_bit && !fifo_empty;

  spi_tx_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .SCLK  (SCLK),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .level (tx_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rx_next = rx_shift;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (bit_cnt == CW'(wire_pos(i, WORD_WIDTH, MSB_FIRST))) rx_next[i] = MOSI;
    end
  end

  always_comb begin
    tx_wire = '0;
    tx_wire[WORD_WIDTH] = tx_flag;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      tx_wire[wire_pos(i, WORD_WIDTH, MSB_FIRST)] = tx_shift[i];
    end
  end

  always_comb begin
    miso_next = 1'b0;
    for (int k = 0; k <= WORD_WIDTH; k++) begin
      if (bit_cnt == CW'(k)) miso_next = tx_wire[k];
    end
  end

  always_ff @(posedge SCLK) begin
    if (!rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
      tx_flag  <= 1'b0;
    end else begin
      bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
      rx_shift <= rx_next;
      rx_valid <= 1'b0;
      if (last_bit) begin
        if (!FLAG_MODE || MOSI) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end
        // Next frame's word comes only from the FIFO head; no same-edge bypass.
        tx_shift <= fifo_empty ? '0 : fifo_rdata;
        tx_flag  <= !fifo_empty;
      end
    end
  end

  // bit_cnt already points at the upcoming wire bit when SCLK falls.
  always_ff @(negedge SCLK) begin
    if (!rst) MISO <= 1'b0;
    else      MISO <= miso_next;
  end

endmodule

// File: tb/tb_spi_slave_framed.sv
// tb/tb_spi_slave_framed.sv - scoreboard bench for spi_slave_framed in three parameter sets
module tb_spi_slave_framed;

  logic       SCLK = 1'b1;
  logic       rst  = 1'b0;
  logic       mosi     [3];
  logic       miso     [3];
  logic [7:0] rx_data  [3];
  logic       rx_valid [3];
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic [2:0] tx_level [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q   [$];
  logic [8:0] exp_miso_q [$];

  always #5 SCLK = ~SCLK;

  spi_slave_framed #(.WORD_WIDTH(8), .TX_DEPTH(4), .FLAG_MODE(1'b0), .MSB_FIRST(1'b0)) dut0 (
    .SCLK(SCLK), .rst(rst), .MOSI(mosi[0]), .MISO(miso[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_level(tx_level[0]));

  spi_slave_framed #(.WORD_WIDTH(8), .TX_DEPTH(4), .FLAG_MODE(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .SCLK(SCLK), .rst(rst), .MOSI(mosi[1]), .MISO(miso[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_level(tx_level[1]));

  spi_slave_framed #(.WORD_WIDTH(8), .TX_DEPTH(4), .FLAG_MODE(1'b0), .MSB_FIRST(1'b1)) dut2 (
    .SCLK(SCLK), .rst(rst), .MOSI(mosi[2]), .MISO(miso[2]), .rx_data(rx_data[2]),
    .rx_valid(rx_valid[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_level(tx_level[2]));

  // Entry and exit point of every step: 1 time unit after a falling edge.
  task automatic step(input int d, input logic m, input logic tv, input logic [7:0] td,
                      output logic rxv);
    mosi[d]     = m;
    tx_valid[d] = tv;
    tx_data[d]  = td;
    @(posedge SCLK); #1;
    rxv = rx_valid[d];
    tx_valid[d] = 1'b0;
    @(negedge SCLK); #1;
  endtask

  task automatic run_frame(input int d, input logic [8:0] mw, input logic push_en,
                           input logic [7:0] pw, output logic [8:0] so,
                           output int vcnt, output int vpos);
    logic rxv;
    vcnt = 0;
    vpos = -1;
    for (int k = 0; k < 9; k++) begin
      so[k] = miso[d];
      step(d, mw[k], push_en && (k == 0), pw, rxv);
      if (rxv) begin
        vcnt++;
        vpos = k;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mosi[d] = 1'b0; tx_valid[d] = 1'b0; tx_data[d] = 8'h00;
    end
    repeat (2) begin
      @(posedge SCLK); #1;
      @(negedge SCLK); #1;
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid[0]); end
    checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data[0]); end
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready[0]); end
    checks++; if (tx_level[0] !== 3'd0) begin errors++; $display("FAIL reset_tx_level got %0d exp 0", tx_level[0]); end
    checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso[0]); end
  endtask

  task automatic test_rx_basic();
    logic [8:0] so; int vc, vp; logic [7:0] er; logic [8:0] em;
    logic [7:0] words [2] = '{8'hA5, 8'h5C};
    logic       pads  [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      exp_rx_q.push_back(words[i]);
      exp_miso_q.push_back(9'h000);
      run_frame(0, {pads[i], words[i]}, 1'b0, 8'h00, so, vc, vp);
      er = exp_rx_q.pop_front();
      em = exp_miso_q.pop_front();
      checks++; if (vc !== 1 || vp !== 8) begin errors++; $display("FAIL rx_pulse_%0d got cnt %0d pos %0d exp cnt 1 pos 8", i, vc, vp); end
      checks++; if (rx_data[0] !== er) begin errors++; $display("FAIL rx_data_%0d got %h exp %h", i, rx_data[0], er); end
      checks++; if (so !== em) begin errors++; $display("FAIL rx_miso_%0d got %h exp %h", i, so, em); end
    end
  endtask

  task automatic test_tx_frames();
    logic [8:0] so; int vc, vp; logic [8:0] em;
    exp_miso_q.push_back(9'h000);
    exp_miso_q.push_back({1'b1, 8'h3C});
    exp_miso_q.push_back(9'h000);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 9'h000, f == 0, 8'h3C, so, vc, vp);
      em = exp_miso_q.pop_front();
      checks++; if (so !== em) begin errors++; $display("FAIL tx_frame_%0d got %h exp %h", f, so, em); end
    end
  endtask

  task automatic test_flag_mode();
    logic [8:0] so; int vc, vp;
    run_frame(1, {1'b0, 8'h11}, 1'b0, 8'h00, so, vc, vp);
    checks++; if (vc !== 0) begin errors++; $display("FAIL flag0_pulse got %0d exp 0", vc); end
    checks++; if (rx_data[1] !== 8'h00) begin errors++; $display("FAIL flag0_data got %h exp 00", rx_data[1]); end
    exp_rx_q.push_back(8'h22);
    run_frame(1, {1'b1, 8'h22}, 1'b0, 8'h00, so, vc, vp);
    checks++; if (vc !== 1 || vp !== 8) begin errors++; $display("FAIL flag1_pulse got cnt %0d pos %0d exp cnt 1 pos 8", vc, vp); end
    checks++; if (rx_data[1] !== exp_rx_q[0]) begin errors++; $display("FAIL flag1_data got %h exp %h", rx_data[1], exp_rx_q[0]); end
    run_frame(1, {1'b0, 8'h33}, 1'b0, 8'h00, so, vc, vp);
    checks++; if (vc !== 0 || rx_data[1] !== exp_rx_q[0]) begin errors++; $display("FAIL flag_hold got cnt %0d data %h exp cnt 0 data %h", vc, rx_data[1], exp_rx_q[0]); end
    void'(exp_rx_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic rxv; logic [8:0] so; int vc, vp; int mdl_level; logic [8:0] em;
    do_reset();
    mdl_level = 0;
    for (int k = 0; k < 5; k++) begin
      if (mdl_level < 4) begin
        exp_miso_q.push_back({1'b1, 8'h10 + 8'(k)});
        mdl_level++;
      end
      step(0, 1'b0, 1'b1, 8'h10 + 8'(k), rxv);
      checks++; if (tx_level[0] !== 3'(mdl_level)) begin errors++; $display("FAIL b2b_level_%0d got %0d exp %0d", k, tx_level[0], mdl_level); end
      checks++; if (tx_ready[0] !== (mdl_level < 4)) begin errors++; $display("FAIL b2b_ready_%0d got %b exp %b", k, tx_ready[0], mdl_level < 4); end
    end
    for (int k = 5; k < 8; k++) step(0, 1'b0, 1'b0, 8'h00, rxv);
    step(0, 1'b0, 1'b1, 8'h99, rxv);
    mdl_level--;
    checks++; if (tx_level[0] !== 3'(mdl_level)) begin errors++; $display("FAIL b2b_full_pop got %0d exp %0d", tx_level[0], mdl_level); end
    exp_miso_q.push_back(9'h000);
    for (int f = 0; f < 5; f++) begin
      run_frame(0, 9'h000, 1'b0, 8'h00, so, vc, vp);
      em = exp_miso_q.pop_front();
      checks++; if (so !== em) begin errors++; $display("FAIL b2b_frame_%0d got %h exp %h", f, so, em); end
    end
  endtask

  task automatic test_msb_first();
    logic [8:0] so; int vc, vp;
    do_reset();
    exp_rx_q.push_back(8'h80);
    run_frame(2, 9'h001, 1'b1, 8'h01, so, vc, vp);
    checks++; if (vc !== 1 || rx_data[2] !== exp_rx_q[0]) begin errors++; $display("FAIL msb_rx got cnt %0d data %h exp cnt 1 data %h", vc, rx_data[2], exp_rx_q[0]); end
    void'(exp_rx_q.pop_front());
    exp_miso_q.push_back(9'h180);
    run_frame(2, 9'h000, 1'b0, 8'h00, so, vc, vp);
    checks++; if (so[7] !== 1'b1) begin errors++; $display("FAIL msb_miso_bit7 got %b exp 1", so[7]); end
    checks++; if (so !== exp_miso_q[0]) begin errors++; $display("FAIL msb_miso got %h exp %h", so, exp_miso_q[0]); end
    void'(exp_miso_q.pop_front());
  endtask

  task automatic test_reset_midframe();
    logic rxv; logic [8:0] so; int vc, vp;
    do_reset();
    step(0, 1'b1, 1'b1, 8'hAA, rxv);
    step(0, 1'b1, 1'b1, 8'hBB, rxv);
    step(0, 1'b1, 1'b0, 8'h00, rxv);
    step(0, 1'b1, 1'b0, 8'h00, rxv);
    checks++; if (tx_level[0] !== 3'd2) begin errors++; $display("FAIL mid_level_pre got %0d exp 2", tx_level[0]); end
    rst = 1'b0;
    step(0, 1'b1, 1'b0, 8'h00, rxv);
    rst = 1'b1;
    checks++; if (tx_level[0] !== 3'd0 || rxv !== 1'b0) begin errors++; $display("FAIL mid_reset got level %0d rxv %b exp level 0 rxv 0", tx_level[0], rxv); end
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(9'h000);
    exp_miso_q.push_back(9'h000);
    run_frame(0, {1'b0, 8'h5A}, 1'b0, 8'h00, so, vc, vp);
    checks++; if (vc !== 1 || vp !== 8 || rx_data[0] !== exp_rx_q[0]) begin errors++; $display("FAIL mid_rx got cnt %0d pos %0d data %h exp cnt 1 pos 8 data %h", vc, vp, rx_data[0], exp_rx_q[0]); end
    void'(exp_rx_q.pop_front());
    for (int f = 0; f < 2; f++) begin
      checks++; if (so !== exp_miso_q[0]) begin errors++; $display("FAIL mid_miso_%0d got %h exp %h", f, so, exp_miso_q[0]); end
      void'(exp_miso_q.pop_front());
      if (f == 0) run_frame(0, 9'h000, 1'b0, 8'h00, so, vc, vp);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      mosi[d] = 1'b0; tx_valid[d] = 1'b0; tx_data[d] = 8'h00;
    end
    @(negedge SCLK); #1;
    do_reset();
    test_reset();
    test_rx_basic();
    test_tx_frames();
    test_flag_mode();
    test_back_to_back();
    test_msb_first();
    test_reset_midframe();
    checks++; if (exp_rx_q.size() != 0 || exp_miso_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d/%0d left exp 0/0", exp_rx_q.size(), exp_miso_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
